// File: rtl/uart_top_if.sv
// rtl/uart_top_if.sv - host handshake, status flags and serial lines of the UART
interface uart_top_if;
   logic [7:0] in_w_data;
   logic       in_valid;
   logic       out_BUSY;
   logic       out_signal;
   logic       in_signal;
   logic       in_RXNE_clear;
   logic [7:0] out_word;
   logic       out_RXNE;
   logic       out_Rx_ORE;

   modport master (
      output in_w_data, in_valid, in_signal, in_RXNE_clear,
      input  out_BUSY, out_signal, out_word, out_RXNE, out_Rx_ORE
   );

   modport slave (
      input  in_w_data, in_valid, in_signal, in_RXNE_clear,
      output out_BUSY, out_signal, out_word, out_RXNE, out_Rx_ORE
   );
endinterface

// File: rtl/uart_top.sv
// rtl/uart_top.sv - 8N1 UART transceiver with independent TX and RX FSMs
// and an RXNE/ORE status pair on the receive side.
module uart_top #(
   parameter int CLK_FREQ_HZ  = 12_000_000,
   parameter int BAUD         = 115_200,
   parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
   input  logic       clk,
   input  logic       i_reset,
   uart_top_if.slave  bus
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_idx;
   logic [7:0]    tx_shift;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         tx_state       <= S_IDLE;
         tx_cnt         <= '0;
         tx_idx         <= '0;
         tx_shift       <= '0;
         bus.out_signal <= 1'b1;
         bus.out_BUSY   <= 1'b0;
      end else begin
         case (tx_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  tx_shift       <= bus.in_w_data;
                  tx_cnt         <= '0;
                  bus.out_signal <= 1'b0;
                  bus.out_BUSY   <= 1'b1;
                  tx_state       <= S_START;
               end
            end
            S_START: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt         <= '0;
                  tx_idx         <= '0;
                  bus.out_signal <= tx_shift[0];
                  tx_shift       <= {1'b0, tx_shift[7:1]};
                  tx_state       <= S_DATA;
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            S_DATA: begin
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_idx == 3'd7) begin
                     bus.out_signal <= 1'b1;
                     tx_state       <= S_STOP;
                  end else begin
                     tx_idx         <= tx_idx + 3'd1;
                     bus.out_signal <= tx_shift[0];
                     tx_shift       <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            S_STOP: begin
               // BUSY drops together with the end of the stop bit so the
               // next request is taken on the very first idle cycle.
               if (tx_cnt == BIT_LAST) begin
                  tx_cnt       <= '0;
                  bus.out_BUSY <= 1'b0;
                  tx_state     <= S_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            default: tx_state <= S_IDLE;
         endcase
      end
   end

   state_t        rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_idx;
   logic [7:0]    rx_shift;
   logic          rx_s1;
   logic          rx_s2;
   logic          stop_hit;

   assign stop_hit = (rx_state == S_STOP) && (rx_cnt == BIT_LAST) && rx_s2;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         rx_state       <= S_IDLE;
         rx_cnt         <= '0;
         rx_idx         <= '0;
         rx_shift       <= '0;
         rx_s1          <= 1'b1;
         rx_s2          <= 1'b1;
         bus.out_word   <= '0;
         bus.out_RXNE   <= 1'b0;
         bus.out_Rx_ORE <= 1'b0;
      end else begin
         rx_s1 <= bus.in_signal;
         rx_s2 <= rx_s1;

         case (rx_state)
            S_IDLE: begin
               if (!rx_s2) begin
                  rx_cnt   <= '0;
                  rx_state <= S_START;
               end
            end
            S_START: begin
               // A line that is high again at mid start bit was a glitch.
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  rx_state <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            S_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  if (rx_idx == 3'd7) rx_state <= S_STOP;
                  else                rx_idx   <= rx_idx + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            S_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= S_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            default: rx_state <= S_IDLE;
         endcase

         // A clear coinciding with a good stop bit frees the slot for the new byte.
         if (stop_hit && (!bus.out_RXNE || bus.in_RXNE_clear)) begin
            bus.out_word   <= rx_shift;
            bus.out_RXNE   <= 1'b1;
            bus.out_Rx_ORE <= 1'b0;
         end else if (bus.in_RXNE_clear) begin
            bus.out_RXNE   <= 1'b0;
            bus.out_Rx_ORE <= 1'b0;
         end else if (stop_hit) begin
            bus.out_Rx_ORE <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_top.sv
// tb/tb_uart_top.sv - scoreboard bench for uart_top: loopback, overrun, busy guard,
// framing/glitch rejection and mid-frame reset.
module tb_uart_top;
   localparam int C = 104;

   logic clk = 1'b0;
   logic i_reset;
   logic loopback;
   logic drv_line;
   logic mon_en;

   always #5 clk = ~clk;

   uart_top_if bus();
   assign bus.in_signal = loopback ? bus.out_signal : drv_line;

   uart_top #(.CLK_FREQ_HZ(12_000_000), .BAUD(115_200)) dut (
      .clk     (clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] seq_bytes [7] = '{8'h00, 8'h53, 8'h41, 8'h34, 8'h57, 8'h36, 8'h53};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Independent decoder of the TX line, sampling each bit at its middle.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && bus.out_signal === 1'b0) begin
            repeat (C / 2) @(negedge clk);
            check("tx_start_bit", 32'(bus.out_signal), 32'h0);
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clk);
               b[i] = bus.out_signal;
            end
            repeat (C) @(negedge clk);
            check("tx_stop_bit", 32'(bus.out_signal), 32'h1);
            check("tx_frame_expected", 32'(tx_q.size() != 0), 32'h1);
            if (tx_q.size() != 0) check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic pulse_valid(input logic [7:0] b);
      @(negedge clk);
      bus.in_w_data = b;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit expect_rx, input bit inject, output int cyc);
      tx_q.push_back(b);
      if (expect_rx) rx_q.push_back(b);
      pulse_valid(b);
      check("tx_line_low_after_accept", 32'(bus.out_signal), 32'h0);
      cyc = 0;
      while (bus.out_BUSY === 1'b1 && cyc < 3000) begin
         cyc++;
         if (inject && cyc == 100) begin
            bus.in_w_data = 8'hFF;
            bus.in_valid  = 1'b1;
         end else begin
            bus.in_valid  = 1'b0;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_rxne(input string tag);
      int n = 0;
      while (bus.out_RXNE !== 1'b1 && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_rxne"}, 32'(bus.out_RXNE), 32'h1);
      check({tag, "_queue"}, 32'(rx_q.size() != 0), 32'h1);
      if (rx_q.size() != 0) check({tag, "_word"}, 32'(bus.out_word), 32'(rx_q.pop_front()));
   endtask

   task automatic clear_flags(input string tag);
      @(negedge clk);
      bus.in_RXNE_clear = 1'b1;
      @(negedge clk);
      bus.in_RXNE_clear = 1'b0;
      check({tag, "_rxne_cleared"}, 32'(bus.out_RXNE), 32'h0);
      check({tag, "_ore_cleared"}, 32'(bus.out_Rx_ORE), 32'h0);
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop);
      if (stop) rx_q.push_back(b);
      drv_line = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drv_line = b[i];
         repeat (C) @(negedge clk);
      end
      drv_line = stop;
      repeat (C) @(negedge clk);
      drv_line = 1'b1;
   endtask

   initial begin
      int cyc;
      i_reset           = 1'b1;
      bus.in_valid      = 1'b0;
      bus.in_w_data     = 8'h00;
      bus.in_RXNE_clear = 1'b0;
      loopback          = 1'b1;
      drv_line          = 1'b1;
      mon_en            = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_signal", 32'(bus.out_signal), 32'h1);
      check("rst_busy",   32'(bus.out_BUSY),   32'h0);
      check("rst_word",   32'(bus.out_word),   32'h0);
      check("rst_rxne",   32'(bus.out_RXNE),   32'h0);
      check("rst_ore",    32'(bus.out_Rx_ORE), 32'h0);
      i_reset = 1'b0;
      mon_en  = 1'b1;
      @(negedge clk);

      send(8'h53, 1'b1, 1'b0, cyc);
      check("busy_len_53", 32'(cyc), 32'd1040);
      wait_rxne("lb53");
      check("lb53_ore", 32'(bus.out_Rx_ORE), 32'h0);
      clear_flags("lb53");

      foreach (seq_bytes[i]) begin
         send(seq_bytes[i], 1'b1, 1'b0, cyc);
         check("busy_len_seq", 32'(cyc), 32'd1040);
         wait_rxne("seq");
         check("seq_ore", 32'(bus.out_Rx_ORE), 32'h0);
         clear_flags("seq");
      end

      send(8'h41, 1'b1, 1'b0, cyc);
      send(8'h33, 1'b0, 1'b0, cyc);
      repeat (20) @(negedge clk);
      wait_rxne("ovr");
      check("ovr_ore_set", 32'(bus.out_Rx_ORE), 32'h1);
      clear_flags("ovr");

      send(8'hA5, 1'b1, 1'b1, cyc);
      check("busy_len_guard", 32'(cyc), 32'd1040);
      wait_rxne("guard");
      clear_flags("guard");
      repeat (2 * C) @(negedge clk);
      check("guard_line_idle", 32'(bus.out_signal), 32'h1);

      loopback = 1'b0;
      drive_frame(8'h5A, 1'b0);
      repeat (2 * C) @(negedge clk);
      check("framing_no_rxne", 32'(bus.out_RXNE), 32'h0);
      drv_line = 1'b0;
      repeat (C / 4) @(negedge clk);
      drv_line = 1'b1;
      repeat (2 * C) @(negedge clk);
      check("glitch_no_rxne", 32'(bus.out_RXNE), 32'h0);
      drive_frame(8'hC3, 1'b1);
      wait_rxne("after_glitch");
      clear_flags("after_glitch");

      mon_en = 1'b0;
      pulse_valid(8'h3C);
      repeat (300) @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      check("midrst_signal", 32'(bus.out_signal), 32'h1);
      check("midrst_busy",   32'(bus.out_BUSY),   32'h0);
      i_reset = 1'b0;
      @(negedge clk);
      loopback = 1'b1;
      mon_en   = 1'b1;
      send(8'h96, 1'b1, 1'b0, cyc);
      check("busy_len_after_rst", 32'(cyc), 32'd1040);
      wait_rxne("after_rst");
      clear_flags("after_rst");

      repeat (C) @(negedge clk);
      check("tx_queue_drained", 32'(tx_q.size()), 32'h0);
      check("rx_queue_drained", 32'(rx_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
